// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// Clocked, self-checking stimulus stage for a combinational truth-table block.
// Sweeps an N_IN-bit vector from 0 to 2^N_IN-1. Each vector is held for SETTLE
// cycles and then sampled for one cycle. The block's 1-bit output is compared
// against the EXPECTED table at each sample.
//
// Parameters:
//   N_IN      number of block inputs (1..8)
//   EXPECTED  expected output table, bit i = expected dut_y for vec == i
//   SETTLE    cycles vec is held before sampling (1..15)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a sweep (accepted only when idle or done)
//   dut_y          output of the block under test
//   vec            stimulus vector, MSB = input A
//   busy           sweep in progress
//   done           sweep finished, held until the next accepted start
//   pass           valid with done, 1 iff no mismatches
//   err_count      mismatches in the current/last sweep
//   err_valid      at least one mismatch recorded this sweep
//   first_err_idx  vec value of the first mismatch (valid with err_valid)
//   obs_table      observed truth table (only with TT_CAPTURE_EN)
//
// Optional feature macro: TT_CAPTURE_EN adds the obs_table capture register.
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
  parameter int unsigned           N_IN     = 4,
  parameter logic [2**N_IN-1:0]    EXPECTED = '0,
  parameter int unsigned           SETTLE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err_idx
`ifdef TT_CAPTURE_EN
  ,
  output logic [2**N_IN-1:0]   obs_table
`endif
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [3:0]      SettleInit = 4'(SETTLE);
  localparam logic [N_IN-1:0] VecLast    = '1;

  // State registers
  logic [1:0]      r_state;
  logic [3:0]      r_settle;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err_count;
  logic            r_err_valid;
  logic [N_IN-1:0] r_first_err_idx;

  // Next-state values
  logic [1:0]      w_state_d;
  logic [3:0]      w_settle_d;
  logic [N_IN-1:0] w_vec_d;
  logic            w_busy_d;
  logic            w_done_d;
  logic            w_pass_d;
  logic [N_IN:0]   w_err_count_d;
  logic            w_err_valid_d;
  logic [N_IN-1:0] w_first_err_idx_d;

  // Compare path
  logic            w_mismatch;
  logic [N_IN:0]   w_err_count_inc;

  assign w_mismatch      = dut_y ^ EXPECTED[r_vec];
  assign w_err_count_inc = r_err_count + (N_IN + 1)'(w_mismatch);

`ifdef TT_CAPTURE_EN
  logic [2**N_IN-1:0] r_obs_table;
  logic [2**N_IN-1:0] w_obs_table_d;
`endif

  always_comb begin
    w_state_d         = r_state;
    w_settle_d        = r_settle;
    w_vec_d           = r_vec;
    w_busy_d          = r_busy;
    w_done_d          = r_done;
    w_pass_d          = r_pass;
    w_err_count_d     = r_err_count;
    w_err_valid_d     = r_err_valid;
    w_first_err_idx_d = r_first_err_idx;
`ifdef TT_CAPTURE_EN
    w_obs_table_d     = r_obs_table;
`endif

    unique case (r_state)
      // IDLE and DONE accept start identically; DONE simply holds its results
      // until then.
      StIdle, StDone: begin
        if (start) begin
          w_state_d         = StDrive;
          w_settle_d        = SettleInit;
          w_vec_d           = '0;
          w_busy_d          = 1'b1;
          w_done_d          = 1'b0;
          w_pass_d          = 1'b0;
          w_err_count_d     = '0;
          w_err_valid_d     = 1'b0;
          w_first_err_idx_d = '0;
`ifdef TT_CAPTURE_EN
          w_obs_table_d     = '0;
`endif
        end
      end

      // Hold vec for exactly SETTLE cycles. The counter is loaded with SETTLE,
      // so leaving when it reads 1 gives SETTLE cycles in this state.
      StDrive: begin
        w_settle_d = r_settle - 4'd1;
        if (r_settle <= 4'd1) begin
          w_state_d = StSample;
        end
      end

      StSample: begin
        if (w_mismatch) begin
          w_err_count_d = w_err_count_inc;
          if (!r_err_valid) begin
            w_err_valid_d     = 1'b1;
            w_first_err_idx_d = r_vec;
          end
        end
`ifdef TT_CAPTURE_EN
        w_obs_table_d[r_vec] = dut_y;
`endif
        if (r_vec == VecLast) begin
          // pass must include the compare made in this very cycle.
          w_state_d = StDone;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_pass_d  = (w_mismatch ? w_err_count_inc : r_err_count) == '0;
        end else begin
          w_state_d  = StDrive;
          w_vec_d    = r_vec + 1'b1;
          w_settle_d = SettleInit;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_settle        <= '0;
      r_vec           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_err_valid     <= 1'b0;
      r_first_err_idx <= '0;
    end else begin
      r_state         <= w_state_d;
      r_settle        <= w_settle_d;
      r_vec           <= w_vec_d;
      r_busy          <= w_busy_d;
      r_done          <= w_done_d;
      r_pass          <= w_pass_d;
      r_err_count     <= w_err_count_d;
      r_err_valid     <= w_err_valid_d;
      r_first_err_idx <= w_first_err_idx_d;
    end
  end

`ifdef TT_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obs_table <= '0;
    end else begin
      r_obs_table <= w_obs_table_d;
    end
  end

  assign obs_table = r_obs_table;
`endif

  assign vec           = r_vec;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign err_valid     = r_err_valid;
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Directed bench for truth_table_sequencer. Three instances share clock, reset
// and start, each driven by a 4-input parity block (dut_y = ^vec):
//   u_ok   EXPECTED=16'h6996, SETTLE=1 : clean sweep
//   u_one  EXPECTED=16'h6997, SETTLE=1 : single error at index 0
//   u_all  EXPECTED=16'h9669, SETTLE=3 : every vector wrong
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;

  logic clk;
  logic rst_n;
  logic start;

  logic [3:0] vec_ok, vec_one, vec_all;
  logic       busy_ok, busy_one, busy_all;
  logic       done_ok, done_one, done_all;
  logic       pass_ok, pass_one, pass_all;
  logic [4:0] ec_ok, ec_one, ec_all;
  logic       ev_ok, ev_one, ev_all;
  logic [3:0] fe_ok, fe_one, fe_all;
`ifdef TT_CAPTURE_EN
  logic [15:0] obs_ok, obs_one, obs_all;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int t_ok, t_one, t_all;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  truth_table_sequencer #(.N_IN(4), .EXPECTED(16'h6996), .SETTLE(1)) u_ok (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_y(^vec_ok),
    .vec(vec_ok), .busy(busy_ok), .done(done_ok), .pass(pass_ok),
    .err_count(ec_ok), .err_valid(ev_ok), .first_err_idx(fe_ok)
`ifdef TT_CAPTURE_EN
    , .obs_table(obs_ok)
`endif
  );

  truth_table_sequencer #(.N_IN(4), .EXPECTED(16'h6997), .SETTLE(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_y(^vec_one),
    .vec(vec_one), .busy(busy_one), .done(done_one), .pass(pass_one),
    .err_count(ec_one), .err_valid(ev_one), .first_err_idx(fe_one)
`ifdef TT_CAPTURE_EN
    , .obs_table(obs_one)
`endif
  );

  truth_table_sequencer #(.N_IN(4), .EXPECTED(16'h9669), .SETTLE(3)) u_all (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_y(^vec_all),
    .vec(vec_all), .busy(busy_all), .done(done_all), .pass(pass_all),
    .err_count(ec_all), .err_valid(ev_all), .first_err_idx(fe_all)
`ifdef TT_CAPTURE_EN
    , .obs_table(obs_all)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is sampled on exactly one rising edge (edge 0).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the accepting edge until each done rises. Optionally
  // pulse start on edges 5 and 12 while the sweep is running.
  task automatic wait_sweep(input bit inject, output int t0, output int t1, output int t2);
    t0 = 0;
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (done_ok  && t0 == 0) t0 = k;
      if (done_one && t1 == 0) t1 = k;
      if (done_all && t2 == 0) t2 = k;
      if (inject) begin
        start = (k == 4) || (k == 11);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_vec",      32'(vec_ok),   32'h0);
    check("rst_busy",     32'(busy_ok),  32'h0);
    check("rst_done",     32'(done_ok),  32'h0);
    check("rst_pass",     32'(pass_ok),  32'h0);
    check("rst_errcnt",   32'(ec_ok),    32'h0);
    check("rst_errvalid", 32'(ev_ok),    32'h0);
    check("rst_firsterr", 32'(fe_ok),    32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start_busy", 32'(busy_ok), 32'h0);

    // Sweep 1, with ignored start pulses at edges 5 and 12
    pulse_start();
    check("start_busy",  32'(busy_ok), 32'h1);
    check("start_vec",   32'(vec_ok),  32'h0);
    check("start_done",  32'(done_ok), 32'h0);
    wait_sweep(1'b1, t_ok, t_one, t_all);
    check("ok_done_latency",  32'(t_ok),  32'd32);
    check("ok_pass",          32'(pass_ok), 32'h1);
    check("ok_errcnt",        32'(ec_ok),   32'h0);
    check("ok_errvalid",      32'(ev_ok),   32'h0);
    check("ok_busy_end",      32'(busy_ok), 32'h0);
    check("ok_vec_end",       32'(vec_ok),  32'hF);
    check("one_done_latency", 32'(t_one), 32'd32);
    check("one_pass",         32'(pass_one), 32'h0);
    check("one_errcnt",       32'(ec_one),   32'h1);
    check("one_errvalid",     32'(ev_one),   32'h1);
    check("one_firsterr",     32'(fe_one),   32'h0);
    check("all_done_latency", 32'(t_all), 32'd64);
    check("all_pass",         32'(pass_all), 32'h0);
    check("all_errcnt",       32'(ec_all),   32'd16);
    check("all_errvalid",     32'(ev_all),   32'h1);
    check("all_firsterr",     32'(fe_all),   32'h0);
`ifdef TT_CAPTURE_EN
    check("ok_obs_table",     32'(obs_ok),   32'h6996);
`endif

    // Restart from DONE
    pulse_start();
    check("restart_done",     32'(done_ok),  32'h0);
    check("restart_errcnt",   32'(ec_ok),    32'h0);
    check("restart_vec",      32'(vec_ok),   32'h0);
    check("restart_busy",     32'(busy_ok),  32'h1);
    check("restart_all_ec",   32'(ec_all),   32'h0);
    check("restart_all_ev",   32'(ev_all),   32'h0);
    check("restart_all_pass", 32'(pass_all), 32'h0);
    wait_sweep(1'b0, t_ok, t_one, t_all);
    check("restart_ok_latency", 32'(t_ok),     32'd32);
    check("restart_ok_pass",    32'(pass_ok),  32'h1);
    check("restart_one_errcnt", 32'(ec_one),   32'h1);
    check("restart_all_errcnt", 32'(ec_all),   32'd16);
`ifdef TT_CAPTURE_EN
    check("restart_obs_table",  32'(obs_ok),   32'h6996);
`endif

    // Reset mid-sweep at edge 10
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    check("mid_vec_before",    32'(vec_ok), 32'h5);
    check("mid_all_ec_before", 32'(ec_all), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_vec",       32'(vec_ok),  32'h0);
    check("async_busy",      32'(busy_ok), 32'h0);
    check("async_all_ec",    32'(ec_all),  32'h0);
    check("async_all_ev",    32'(ev_all),  32'h0);
    check("async_one_ev",    32'(ev_one),  32'h0);
    check("async_all_busy",  32'(busy_all), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_done",   32'(done_ok), 32'h0);
    pulse_start();
    wait_sweep(1'b0, t_ok, t_one, t_all);
    check("post_rst_latency", 32'(t_ok),    32'd32);
    check("post_rst_pass",    32'(pass_ok), 32'h1);
    check("post_rst_errcnt",  32'(ec_ok),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
